blood_sprite_renderer: RTL and testbench
========================================

BLOOD_SPRITE_RENDERER -- requirements
Module: blood_sprite_renderer

Interface
REQ-001 Parameter: NUM_FRAMES, 32, number of blood animation frames, range 2..32.
REQ-002 Parameter: TICKS_PER_FRAME, 2, frame_tick pulses per animation step, range 1..15.
REQ-003 Port: clk  in  1  single system clock; all logic SHALL be on its rising edge.
REQ-004 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port: x, y  in  10 each  current VGA pixel coordinate.
REQ-006 Port: video_on  in  1  high in the active display area.
REQ-007 Port: bg_rgb  in  12  background pixel for the same x,y, time-aligned with x,y.
REQ-008 Port: frame_tick  in  1  one-cycle pulse once per video frame, at vblank start.
REQ-009 Port: trigger  in  1  one-cycle pulse that starts or restarts the animation.
REQ-010 Port: pos_x, pos_y  in  10 each  sprite top-left corner, sampled on trigger.
REQ-011 Port: rom_frame  out  5  selected blood frame index to the frame ROM mux.
REQ-012 Port: rom_row, rom_col  out  6 each  address to the 64x64 frame ROM.
REQ-013 Port: rom_data  in  12  ROM colour, valid one cycle after the address.
REQ-014 Port: rgb  out  12  composited pixel; busy  out  1  animation running; done  out  1  end pulse.

Function
REQ-015 The FSM SHALL have two states, IDLE and PLAY; busy SHALL be 1 exactly in PLAY.
REQ-016 A trigger in any state SHALL enter PLAY, latch pos_x/pos_y, and clear the frame index and tick counter to 0. A trigger in PLAY SHALL override a coincident frame_tick.
REQ-017 In PLAY, each frame_tick SHALL increment the tick counter. On reaching TICKS_PER_FRAME-1 it SHALL clear the counter and advance the frame index.
REQ-018 An advance from frame NUM_FRAMES-1 SHALL return the FSM to IDLE, set the frame index to 0, and pulse done for exactly one cycle.
REQ-019 The frame index SHALL change only on a frame_tick cycle or on trigger, so no frame tears mid-scan.
REQ-020 rom_frame SHALL equal the frame index; rom_row and rom_col SHALL be combinational from x, y and the latched position.
- rom_row = (y - pos_y)[5:0]; rom_col = (x - pos_x)[5:0].
REQ-021 in_sprite SHALL use 11-bit signed differences dx = x - pos_x and dy = y - pos_y, and SHALL be true only when 0 <= dx <= 63 and 0 <= dy <= 63. Sprites at screen edges SHALL NOT wrap.
REQ-022 in_sprite, video_on and bg_rgb SHALL be delayed one stage to align with rom_data.
REQ-023 rgb SHALL be registered, giving a total latency of 2 clk cycles from x,y to rgb.
REQ-024 Delayed video_on = 0 SHALL give rgb = 12'h000.
REQ-025 IDLE, not in_sprite, or rom_data == 12'h000 (transparent) SHALL give rgb = bg_rgb; otherwise rgb = rom_data.

Reset
REQ-026 reset_n low SHALL immediately force: state IDLE, frame index 0, tick counter 0, latched position 0, all pipeline registers 0, rgb 0, busy 0, done 0.
REQ-027 Reset asserted mid-animation SHALL abort it with no done pulse. The first trigger after reset release SHALL start from frame 0.

Configuration
REQ-028 Macro BLOOD_MIRROR_EN SHALL add input face_left (1 bit), sampled on trigger.
- When the latched value is 1, rom_col SHALL be 63 - dx[5:0].
- Without the macro, the port SHALL be absent and rom_col SHALL be unmirrored.

Structure
REQ-029 A shared package SHALL hold: SPRITE_DIM = 64, TRANSPARENT_RGB = 12'h000, the colour width of 12, and the IDLE/PLAY state encoding.
REQ-030 The FSM, tick counter and frame index SHALL live in sub-module blood_frame_sequencer. The address, compositing and pipeline logic SHALL stay in the top module.

Verification
REQ-031 NUM_FRAMES=4, TICKS_PER_FRAME=2: trigger, then 8 frame_ticks -> rom_frame 0,0,1,1,2,2,3,3 → IDLE; done high exactly 1 cycle after the 8th tick; busy 0 afterwards.
REQ-032 pos=(100,50), x=163, y=50, rom_data=12'hD00 -> rgb 12'hD00 two cycles later. At x=164 -> rgb = bg_rgb.
REQ-033 rom_data=12'h000 inside the sprite, bg_rgb=12'h0F0 -> rgb 12'h0F0. Same pixel with video_on=0 -> rgb 12'h000.
REQ-034 Retrigger at frame 2 coincident with a frame_tick -> rom_frame 0, tick counter 0, new position latched, no done pulse.
REQ-035 pos_x=1000, x=5 -> in_sprite false, no wrap. BLOOD_MIRROR_EN with face_left=1, dx=0 -> rom_col 63.
REQ-036 reset_n pulsed low mid-PLAY, asynchronous to clk -> outputs 0 without waiting for a clock edge, no done pulse.

Source files
------------

// File: rtl/blood_sprite_renderer_pkg.sv
// Shared definitions for the blood sprite renderer: sprite geometry, colour
// width, the transparent key colour and the sequencer state encoding.
package blood_sprite_renderer_pkg;
   localparam int SPRITE_DIM = 64;
   localparam int RGB_W      = 12;
   localparam logic [RGB_W-1:0] TRANSPARENT_RGB = 12'h000;

   typedef enum logic {
      IDLE = 1'b0,
      PLAY = 1'b1
   } state_t;
endpackage

// File: rtl/blood_sprite_renderer_if.sv
// Video pixel stream and frame-ROM bus of the blood sprite renderer.
//   x, y, video_on, bg_rgb : incoming pixel coordinate / background colour
//   rom_frame, rom_row, rom_col : frame ROM address (from renderer)
//   rom_data               : ROM colour, one cycle after the address
//   rgb                    : composited pixel (from renderer)
// master = video source / ROM side, slave = renderer.
interface blood_sprite_renderer_if;
   import blood_sprite_renderer_pkg::*;
   logic [9:0]       x;
   logic [9:0]       y;
   logic             video_on;
   logic [RGB_W-1:0] bg_rgb;
   logic [4:0]       rom_frame;
   logic [5:0]       rom_row;
   logic [5:0]       rom_col;
   logic [RGB_W-1:0] rom_data;
   logic [RGB_W-1:0] rgb;

   modport master (output x, y, video_on, bg_rgb, rom_data,
                   input  rom_frame, rom_row, rom_col, rgb);
   modport slave  (input  x, y, video_on, bg_rgb, rom_data,
                   output rom_frame, rom_row, rom_col, rgb);
endinterface

// File: rtl/blood_sprite_renderer_sequencer.sv
// blood_frame_sequencer: IDLE/PLAY state machine that steps the blood
// animation. Frame index and tick counter only move on trigger or
// frame_tick, so the displayed frame never changes mid-scan.
//   clk, reset_n         : clock, async active-low reset
//   trigger, frame_tick  : start/restart pulse, once-per-video-frame pulse
//   frame_idx            : current animation frame
//   busy, done           : PLAY state, one-cycle end-of-animation pulse
module blood_frame_sequencer
   import blood_sprite_renderer_pkg::*;
#(
   parameter int NUM_FRAMES      = 32,
   parameter int TICKS_PER_FRAME = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       trigger,
   input  logic       frame_tick,
   output logic [4:0] frame_idx,
   output logic       busy,
   output logic       done
);
   state_t     state, state_nxt;
   logic [4:0] frame_nxt;
   logic [3:0] tick_cnt, tick_nxt;
   logic       done_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         frame_idx <= '0;
         tick_cnt  <= '0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         frame_idx <= frame_nxt;
         tick_cnt  <= tick_nxt;
         done      <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      frame_nxt = frame_idx;
      tick_nxt  = tick_cnt;
      done_nxt  = 1'b0;
      // trigger wins over a coincident frame_tick
      if (trigger) begin
         state_nxt = PLAY;
         frame_nxt = '0;
         tick_nxt  = '0;
      end else if (state == PLAY && frame_tick) begin
         if (tick_cnt == 4'(TICKS_PER_FRAME - 1)) begin
            tick_nxt = '0;
            if (frame_idx == 5'(NUM_FRAMES - 1)) begin
               state_nxt = IDLE;
               frame_nxt = '0;
               done_nxt  = 1'b1;
            end else begin
               frame_nxt = frame_idx + 5'd1;
            end
         end else begin
            tick_nxt = tick_cnt + 4'd1;
         end
      end
   end

   assign busy = (state == PLAY);
endmodule

// File: rtl/blood_sprite_renderer.sv
// blood_sprite_renderer: overlays a 64x64 animated blood sprite onto the VGA
// pixel stream. Address is combinational from x,y; rom_data comes back one
// cycle later; rgb is registered, so x,y -> rgb is 2 cycles.
//   clk, reset_n         : clock, async active-low reset
//   trigger, pos_x/pos_y : start animation at a latched top-left corner
//   frame_tick           : vblank pulse that paces the animation
//   face_left            : horizontal mirror, only with BLOOD_MIRROR_EN
//   vid (slave)          : pixel stream in, ROM address/data, rgb out
//   busy, done           : animation running, end pulse
// Optional feature macro: BLOOD_MIRROR_EN.
module blood_sprite_renderer
   import blood_sprite_renderer_pkg::*;
#(
   parameter int NUM_FRAMES      = 32,
   parameter int TICKS_PER_FRAME = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       trigger,
   input  logic       frame_tick,
   input  logic [9:0] pos_x,
   input  logic [9:0] pos_y,
`ifdef BLOOD_MIRROR_EN
   input  logic       face_left,
`endif
   blood_sprite_renderer_if.slave vid,
   output logic       busy,
   output logic       done
);
   logic [9:0]       pos_x_q, pos_y_q;
   logic             face_q;
   logic [10:0]      dx, dy;
   logic             in_sprite;
   logic             vis_d, von_d;
   logic [RGB_W-1:0] bg_d, rgb_q;

   blood_frame_sequencer #(
      .NUM_FRAMES      (NUM_FRAMES),
      .TICKS_PER_FRAME (TICKS_PER_FRAME)
   ) u_seq (
      .clk        (clk),
      .reset_n    (reset_n),
      .trigger    (trigger),
      .frame_tick (frame_tick),
      .frame_idx  (vid.rom_frame),
      .busy       (busy),
      .done       (done)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pos_x_q <= '0;
         pos_y_q <= '0;
         face_q  <= 1'b0;
      end else if (trigger) begin
         pos_x_q <= pos_x;
         pos_y_q <= pos_y;
`ifdef BLOOD_MIRROR_EN
         face_q  <= face_left;
`else
         face_q  <= 1'b0;
`endif
      end
   end

   // zero-extended 11-bit differences: bit 10 is the sign, so a sprite near
   // the right/bottom edge never wraps onto the left/top of the screen
   assign dx = {1'b0, vid.x} - {1'b0, pos_x_q};
   assign dy = {1'b0, vid.y} - {1'b0, pos_y_q};
   assign in_sprite = !dx[10] && (dx[9:6] == 4'd0) && !dy[10] && (dy[9:6] == 4'd0);

   assign vid.rom_row = dy[5:0];
   assign vid.rom_col = face_q ? ~dx[5:0] : dx[5:0];  // ~d == 63 - d

   // stage 1: align sprite hit / video_on / background with rom_data;
   // the IDLE check is folded into the hit so it stays pixel-aligned
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vis_d <= 1'b0;
         von_d <= 1'b0;
         bg_d  <= '0;
      end else begin
         vis_d <= busy && in_sprite;
         von_d <= vid.video_on;
         bg_d  <= vid.bg_rgb;
      end
   end

   // stage 2: composite
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         rgb_q <= '0;
      else if (!von_d)
         rgb_q <= '0;
      else if (vis_d && vid.rom_data != TRANSPARENT_RGB)
         rgb_q <= vid.rom_data;
      else
         rgb_q <= bg_d;
   end

   assign vid.rgb = rgb_q;
endmodule

// File: tb/tb_blood_sprite_renderer.sv
module tb_blood_sprite_renderer;
   import blood_sprite_renderer_pkg::*;
   localparam int NF  = 4;
   localparam int TPF = 2;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       trigger = 1'b0;
   logic       frame_tick = 1'b0;
   logic [9:0] pos_x = '0, pos_y = '0;
   logic       busy, done;
   logic       face_left = 1'b0;

   blood_sprite_renderer_if vif();

   blood_sprite_renderer #(.NUM_FRAMES(NF), .TICKS_PER_FRAME(TPF)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .trigger    (trigger),
      .frame_tick (frame_tick),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
`ifdef BLOOD_MIRROR_EN
      .face_left  (face_left),
`endif
      .vid        (vif),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Animation progress is tracked as "frame_ticks since trigger"; the frame
   // shown is that count divided by TPF, and the run ends after NF*TPF ticks.
   bit m_play, m_done, m_face;
   int m_ticks, m_px, m_py;
   bit s_vis, s_von;
   int s_bg, m_rgb;

   function automatic int m_frame();
      return m_play ? m_ticks / TPF : 0;
   endfunction

   function automatic bit hit(int x, int y, int px, int py);
      return (x - px >= 0) && (x - px < SPRITE_DIM) && (y - py >= 0) && (y - py < SPRITE_DIM);
   endfunction

   initial begin : model
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            m_play = 0; m_done = 0; m_face = 0; m_ticks = 0; m_px = 0; m_py = 0;
            s_vis = 0; s_von = 0; s_bg = 0; m_rgb = 0;
         end else begin
            m_rgb = !s_von ? 0 : (s_vis && vif.rom_data != 0) ? int'(vif.rom_data) : s_bg;
            s_vis = m_play && hit(int'(vif.x), int'(vif.y), m_px, m_py);
            s_von = vif.video_on;
            s_bg  = int'(vif.bg_rgb);
            m_done = 0;
            if (trigger) begin
               m_play = 1; m_ticks = 0; m_px = int'(pos_x); m_py = int'(pos_y);
`ifdef BLOOD_MIRROR_EN
               m_face = face_left;
`endif
            end else if (m_play && frame_tick) begin
               m_ticks++;
               if (m_ticks == NF * TPF) begin
                  m_play = 0; m_ticks = 0; m_done = 1;
               end
            end
         end
      end
   end

   initial begin : compare
      int c;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            c = (int'(vif.x) - m_px) & 63;
            if (m_face) c = 63 - c;
            check("m_rgb", 32'(vif.rgb), 32'(m_rgb));
            check("m_busy", 32'(busy), 32'(m_play));
            check("m_done", 32'(done), 32'(m_done));
            check("m_frame", 32'(vif.rom_frame), 32'(m_frame()));
            check("m_row", 32'(vif.rom_row), 32'((int'(vif.y) - m_py) & 63));
            check("m_col", 32'(vif.rom_col), 32'(c));
         end
      end
   end

   // ---------------- stimulus helpers (all start/end at posedge+1) ----------------
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic trig(int px, int py, bit fl);
      trigger = 1; pos_x = 10'(px); pos_y = 10'(py); face_left = fl;
      step();
      trigger = 0;
   endtask

   task automatic tick();
      frame_tick = 1;
      step();
      frame_tick = 0;
   endtask

   task automatic pix(string name, int x, int y, bit von, int bg, int rom, int exp);
      vif.x = 10'(x); vif.y = 10'(y); vif.video_on = von; vif.bg_rgb = 12'(bg);
      step();
      vif.rom_data = 12'(rom);
      step();
      check(name, 32'(vif.rgb), 32'(exp));
   endtask

   int seq[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
   int cur_px = 0, cur_py = 0;

   initial begin
      vif.x = '0; vif.y = '0; vif.video_on = 0; vif.bg_rgb = '0; vif.rom_data = '0;
      #2;
      check("rst_rgb", 32'(vif.rgb), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_frame", 32'(vif.rom_frame), 0);
      step();
      reset_n = 1;
      chk_en = 1;
      step();

      // full animation sequence
      trig(10, 10, 0);
      for (int i = 0; i < 8; i++) begin
         check("seq_frame", 32'(vif.rom_frame), 32'(seq[i]));
         step();
         tick();
      end
      check("seq_done", 32'(done), 1);
      check("seq_busy", 32'(busy), 0);
      step();
      check("seq_done_low", 32'(done), 0);

      // compositing
      trig(100, 50, 0);
      pix("edge_in",  163, 50, 1, 12'h00F, 12'hD00, 12'hD00);
      pix("edge_out", 164, 50, 1, 12'h00F, 12'hD00, 12'h00F);
      pix("transp",   120, 60, 1, 12'h0F0, 12'h000, 12'h0F0);
      pix("blank",    120, 60, 0, 12'h0F0, 12'h000, 12'h000);

      // retrigger coincident with a tick at frame 2
      for (int i = 0; i < 4; i++) tick();
      check("rt_pre", 32'(vif.rom_frame), 2);
      trigger = 1; frame_tick = 1; pos_x = 200; pos_y = 300;
      vif.x = 205; vif.y = 303;
      step();
      trigger = 0; frame_tick = 0;
      check("rt_frame", 32'(vif.rom_frame), 0);
      check("rt_busy", 32'(busy), 1);
      check("rt_done", 32'(done), 0);
      check("rt_col", 32'(vif.rom_col), 5);
      check("rt_row", 32'(vif.rom_row), 3);
      tick();
      check("rt_tick0", 32'(vif.rom_frame), 0);
      tick();
      check("rt_tick1", 32'(vif.rom_frame), 1);

      // right-edge sprite must not wrap
      trig(1000, 100, 0);
      pix("nowrap", 5, 110, 1, 12'h123, 12'hABC, 12'h123);
`ifdef BLOOD_MIRROR_EN
      trig(300, 200, 1);
      vif.x = 300; vif.y = 200;
      #1 check("mirror_col", 32'(vif.rom_col), 63);
      step();
`endif

      // async reset mid-play
      trig(40, 40, 0);
      tick(); tick(); tick();
      @(posedge clk); #3;
      reset_n = 0;
      #1;
      check("ar_busy", 32'(busy), 0);
      check("ar_done", 32'(done), 0);
      check("ar_rgb", 32'(vif.rgb), 0);
      check("ar_frame", 32'(vif.rom_frame), 0);
      step();
      reset_n = 1;
      step(); step();
      trig(40, 40, 0);
      check("ar_restart", 32'(vif.rom_frame), 0);
      tick(); tick();
      check("ar_restart1", 32'(vif.rom_frame), 1);

      // randomized run
      for (int n = 0; n < 3000; n++) begin
         trigger = ($urandom_range(0, 59) == 0);
         frame_tick = ($urandom_range(0, 2) == 0);
         pos_x = 10'($urandom); pos_y = 10'($urandom);
         face_left = 1'($urandom);
         if (trigger) begin cur_px = pos_x; cur_py = pos_y; end
         if ($urandom_range(0, 7) == 0) begin
            vif.x = 10'($urandom); vif.y = 10'($urandom);
         end else begin
            vif.x = 10'(cur_px + int'($urandom_range(0, 79)) - 8);
            vif.y = 10'(cur_py + int'($urandom_range(0, 79)) - 8);
         end
         vif.video_on = ($urandom_range(0, 5) != 0);
         vif.bg_rgb = 12'($urandom);
         vif.rom_data = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
         step();
      end
      trigger = 0; frame_tick = 0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
